parity_rx: RTL and testbench
============================

PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the number of data bits per frame (legal 1..16).
REQ-002 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port bit_en  input  1  sample strobe; rx_bit is sampled only on edges where bit_en=1.
REQ-006 SHALL have port rx_bit  input  1  serial line bit (idle level 1).
REQ-007 SHALL have port data  output  DATA_W  last received data word.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking a completed frame.
REQ-009 SHALL have port parity_err  output  1  parity mismatch flag for the last frame.
REQ-010 SHALL have port frame_err  output  1  stop bit was 0 for the last frame.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL receive frames in this order: start bit (0), then DATA_W data bits LSB first, then 1 parity bit, then 1 stop bit (1).
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY and STOP, and SHALL never advance on an edge with bit_en=0 (all registers hold).
REQ-014 In IDLE with bit_en=1, rx_bit=0 SHALL enter DATA with bit count 0 and running parity cleared; rx_bit=1 SHALL stay in IDLE.
REQ-015 In DATA on each bit_en SHALL shift rx_bit into position [count] (LSB first) and XOR it into the running parity; after the DATA_W-th bit SHALL enter PARITY.
REQ-016 In PARITY on bit_en SHALL latch mismatch = running_parity XOR rx_bit XOR PARITY_ODD (1 = error) and enter STOP.
REQ-017 In STOP on bit_en SHALL, at that same edge, load data with the shift register, load parity_err with the latched mismatch, load frame_err with NOT rx_bit, set valid=1 and return to IDLE.
REQ-018 valid SHALL be high for exactly one clk cycle (the cycle after the stop-bit sampling edge), independent of bit_en spacing.
REQ-019 data, parity_err and frame_err SHALL change only on the valid edge and hold until the next valid edge.
REQ-020 A frame with frame_err=1 SHALL still deliver data and valid=1; there is no resynchronisation hunt beyond returning to IDLE.
REQ-021 A new start bit SHALL be accepted on the very next bit_en after the stop bit (back-to-back frames with no idle bit).
REQ-022 Latency: valid SHALL rise 1 clk after the stop bit is sampled; total frame = DATA_W+3 bit_en strobes.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE and count=0, clear the shift register and running parity, and set data=0, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame; no valid SHALL follow the release of reset until a full new frame is received.

Verification
REQ-025 Scenario: frame 0xA5, parity 0, stop 1, PARITY_ODD=0, bit_en every cycle -> data=0xA5, one valid pulse, parity_err=0, frame_err=0, valid 12 cycles after the start bit edge.
REQ-026 Scenario: frame 0x01, parity bit 0 (wrong for even parity) -> data=0x01, valid=1, parity_err=1, frame_err=0.
REQ-027 Scenario: frame 0x3C, correct parity 0, stop bit 0 -> data=0x3C, valid=1, parity_err=0, frame_err=1.
REQ-028 Scenario: bit_en once every 4 cycles, frame 0x5A -> data=0x5A; valid high for exactly 1 cycle; busy high from the start-bit edge through the stop-bit edge.
REQ-029 Scenario: rst pulsed after 4 data bits, then full frame 0xFF with parity 0 -> exactly one valid, data=0xFF, no errors.
REQ-030 Scenario: back-to-back 0x3C then 0xC3 with no idle bit, and PARITY_ODD=1 run of 0x07 with parity 0 -> two valids with data 0x3C, 0xC3; then 0x07 with parity_err=0.

Source files
------------

// File: rtl/parity_rx.sv
// -----------------------------------------------------------------------------
// parity_rx
//
// Serial frame receiver with parity and stop-bit checking. A frame is a start
// bit (0), DATA_W data bits sent LSB first, one parity bit and one stop bit (1).
// The line is only looked at on clock edges where the sample strobe bit_en is
// high, so the bit rate is set entirely by how often bit_en is pulsed. On the
// edge that samples the stop bit the received word and both error flags are
// published and valid pulses for one clock.
//
// Parameters
//   DATA_W      data bits per frame (1..16)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports
//   clk         clock; all state changes on its rising edge
//   rst         asynchronous, active-high reset
//   bit_en      sample strobe; rx_bit is only taken on edges where it is 1
//   rx_bit      serial line (idles at 1)
//   data        last received data word
//   valid       one-clock pulse marking a completed frame
//   parity_err  parity mismatch flag for the last frame
//   frame_err   stop bit of the last frame was 0
//   busy        receiver is inside a frame (FSM not in IDLE)
// -----------------------------------------------------------------------------
module parity_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // Bit counter wide enough to index every data bit; keep at least one bit
    // so a single-bit frame still has a legal counter.
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             ODD      = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  shift_reg;
    logic               run_par;
    logic               mismatch;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked assignment uses <= so all registers update together
    // from values sampled before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: the FSM only moves on strobed edges.
    // -------------------------------------------------------------------------
    // NOTE: state_nxt is given a value before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!rx_bit) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (count == LAST_BIT) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: bit capture, running parity and frame results.
    // valid is cleared on every edge so it stays a single-clock pulse no matter
    // how widely the strobes are spaced; everything else holds between strobes.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            shift_reg  <= '0;
            run_par    <= 1'b0;
            mismatch   <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!rx_bit) begin
                            count     <= '0;
                            shift_reg <= '0;
                            run_par   <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_reg[count] <= rx_bit;
                        run_par          <= run_par ^ rx_bit;
                        count            <= count + 1'b1;
                    end
                    PARITY: begin
                        // Data ones plus the parity bit must be even (or odd
                        // in odd mode); a 1 here flags a violation.
                        mismatch <= run_par ^ rx_bit ^ ODD;
                    end
                    STOP: begin
                        data       <= shift_reg;
                        parity_err <= mismatch;
                        frame_err  <= ~rx_bit;
                        valid      <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_rx
//
// Drives two receivers (even and odd parity) from the same serial stimulus.
// A table of directed frames with their expected results is applied first,
// followed by a mid-frame reset sequence and a run of random frames whose
// expected results come from a frame-level parity model. A monitor counts
// valid cycles and watches that the result outputs only move on valid.
// -----------------------------------------------------------------------------
module tb_parity_rx;

    localparam int DATA_W = 8;
    localparam int N_VEC  = 10;
    localparam int N_RAND = 60;

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic              bit_en = 1'b0;
    logic              rx_bit = 1'b1;

    logic [DATA_W-1:0] data_e, data_o;
    logic              valid_e, valid_o;
    logic              pe_e, pe_o;
    logic              fe_e, fe_o;
    logic              busy_e, busy_o;

    parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(0)) dut_even (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx_bit     (rx_bit),
        .data       (data_e),
        .valid      (valid_e),
        .parity_err (pe_e),
        .frame_err  (fe_e),
        .busy       (busy_e)
    );

    parity_rx #(.DATA_W(DATA_W), .PARITY_ODD(1)) dut_odd (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx_bit     (rx_bit),
        .data       (data_o),
        .valid      (valid_o),
        .parity_err (pe_o),
        .frame_err  (fe_o),
        .busy       (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp      = 0;
    int n_bad      = 0;
    int exp_frames = 0;
    int seen_e     = 0;
    int seen_o     = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Frame-level parity model: count all ones in data plus the parity bit;
    // even mode wants an even total, odd mode an odd total.
    function automatic logic ref_perr(input logic [DATA_W-1:0] d, input logic p, input bit odd);
        int ones;
        ones = int'(p);
        for (int i = 0; i < DATA_W; i++) begin
            ones = ones + int'(d[i]);
        end
        return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    // Present inputs, let one rising edge take them, return 1 ns after it.
    task automatic tick(input logic en, input logic b);
        bit_en = en;
        rx_bit = b;
        @(posedge clk);
        #1;
    endtask

    // Result outputs must not move except in a valid cycle.
    logic [DATA_W+1:0] snap_e, snap_o, prev_e, prev_o;
    assign snap_e = {data_e, pe_e, fe_e};
    assign snap_o = {data_o, pe_o, fe_o};

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_e) seen_e++;
            else check("hold_even", 32'(snap_e), 32'(prev_e));
            if (valid_o) seen_o++;
            else check("hold_odd", 32'(snap_o), 32'(prev_o));
        end
        prev_e = snap_e;
        prev_o = snap_o;
    end

    // Send one frame with 'gap' clocks per bit (bit_en on the first of them),
    // checking busy/valid after every clock and the results after the stop bit.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                              input int gap, input logic [DATA_W-1:0] exp_d,
                              input logic exp_pe_e, input logic exp_pe_o,
                              input logic exp_fe, input string tag);
        logic bits[$];
        int   ticks;
        int   lat;
        logic exp_busy;
        ticks = 0;
        lat   = -1;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        bits.push_back(p);
        bits.push_back(s);
        for (int k = 0; k < bits.size(); k++) begin
            tick(1'b1, bits[k]);
            ticks++;
            if (valid_e && lat < 0) lat = ticks + 1;
            exp_busy = (k < DATA_W + 2);
            check({tag, "_busy_e"}, 32'(busy_e), 32'(exp_busy));
            check({tag, "_busy_o"}, 32'(busy_o), 32'(exp_busy));
            check({tag, "_valid_e"}, 32'(valid_e), 32'(k == DATA_W + 2));
            check({tag, "_valid_o"}, 32'(valid_o), 32'(k == DATA_W + 2));
            if (k == DATA_W + 2) begin
                exp_frames++;
                check({tag, "_data_e"}, 32'(data_e), 32'(exp_d));
                check({tag, "_data_o"}, 32'(data_o), 32'(exp_d));
                check({tag, "_perr_e"}, 32'(pe_e), 32'(exp_pe_e));
                check({tag, "_perr_o"}, 32'(pe_o), 32'(exp_pe_o));
                check({tag, "_ferr_e"}, 32'(fe_e), 32'(exp_fe));
                check({tag, "_ferr_o"}, 32'(fe_o), 32'(exp_fe));
            end
            for (int g = 1; g < gap; g++) begin
                tick(1'b0, 1'($urandom_range(0, 1)));
                ticks++;
                if (valid_e && lat < 0) lat = ticks + 1;
                check({tag, "_gap_busy_e"}, 32'(busy_e), 32'(exp_busy));
                check({tag, "_gap_valid_e"}, 32'(valid_e), 32'(0));
                check({tag, "_gap_valid_o"}, 32'(valid_o), 32'(0));
            end
        end
        // Counting the start-bit cycle as cycle 1, valid shows in the cycle
        // after the stop strobe: cycle 12 for 8 data bits with bit_en always on.
        check({tag, "_latency"}, 32'(lat), 32'((DATA_W + 2) * gap + 2));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy_e"},  32'(busy_e),  32'(0));
        check({tag, "_busy_o"},  32'(busy_o),  32'(0));
        check({tag, "_valid_e"}, 32'(valid_e), 32'(0));
        check({tag, "_valid_o"}, 32'(valid_o), 32'(0));
        check({tag, "_data_e"},  32'(data_e),  32'(0));
        check({tag, "_data_o"},  32'(data_o),  32'(0));
        check({tag, "_perr_e"},  32'(pe_e),    32'(0));
        check({tag, "_perr_o"},  32'(pe_o),    32'(0));
        check({tag, "_ferr_e"},  32'(fe_e),    32'(0));
        check({tag, "_ferr_o"},  32'(fe_o),    32'(0));
    endtask

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              p;
        logic              s;
        int                gap;
        logic [DATA_W-1:0] exp_d;
        logic              exp_pe_e;
        logic              exp_pe_o;
        logic              exp_fe;
    } vec_t;

    vec_t vecs [N_VEC];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the test completed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic              p;
        logic              s;
        int                gap;

        //           data   par   stop  gap  exp_d  pe_e  pe_o  fe
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 4, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 1, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h07, 1'b0, 1'b1, 1, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 2, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 1'b0, 1'b1, 3, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{8'h80, 1'b1, 1'b1, 1, 8'h80, 1'b0, 1'b1, 1'b0};

        // Power-on reset.
        rst = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        check_reset_values("por");
        rst = 1'b0;

        // Idle-level strobes must not start a frame.
        repeat (3) begin
            tick(1'b1, 1'b1);
            check("idle_busy_e", 32'(busy_e), 32'(0));
            check("idle_busy_o", 32'(busy_o), 32'(0));
        end

        // Directed frames, back to back with no idle bit between them.
        for (int i = 0; i < N_VEC; i++) begin
            send_frame(vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].gap, vecs[i].exp_d,
                       vecs[i].exp_pe_e, vecs[i].exp_pe_o, vecs[i].exp_fe,
                       $sformatf("vec%0d", i));
        end

        // Reset after four data bits: the partial frame must vanish at once.
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b1, 1'b1);
        check("mid_busy_e", 32'(busy_e), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        rst = 1'b0;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("post_rst_busy_e", 32'(busy_e), 32'(0));
        send_frame(8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b1, 1'b0, "after_rst");

        // Random frames against the parity model.
        for (int n = 0; n < N_RAND; n++) begin
            d   = DATA_W'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 7) != 0);
            gap = int'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1);
            send_frame(d, p, s, gap, d, ref_perr(d, p, 1'b0), ref_perr(d, p, 1'b1), !s, "rand");
        end

        repeat (4) tick(1'b1, 1'b1);
        check("valid_count_e", 32'(seen_e), 32'(exp_frames));
        check("valid_count_o", 32'(seen_o), 32'(exp_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
